// File: rtl/mult_div_unit.sv
`timescale 1ns/1ps
// EX-stage multiply/divide unit holding the architectural HI/LO registers.
// Latency: mult/multu MULT_CYCLES, div/divu DIV_CYCLES busy cycles; mthi/mtlo one edge; MD_out combinational.
// Backpressure: none internally; busy tells the hazard unit to stall MD-class ops, and a start while busy is dropped.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MD_op,
    input  logic        start,
    input  logic        Req,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MD_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        busy_q;
    logic        commit_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] temp_hi_q, temp_lo_q;

    logic [31:0] res_hi_d, res_lo_d;
    logic        commit_d;
    logic        is_md_start;
    logic        is_mult;
    logic [63:0] a_sx, b_sx;
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag;
    logic [31:0] dvd, dvs;
    logic [31:0] q_raw, r_raw;
    logic        signed_div;
    logic [31:0] md_out_d;

    assign is_md_start = start && (MD_op >= OP_MULT) && (MD_op <= OP_DIVU);
    assign is_mult     = (MD_op == OP_MULT) || (MD_op == OP_MULTU);
    assign signed_div  = (MD_op == OP_DIV);

    // Result datapath: both products plus one shared magnitude divider;
    // signed division divides magnitudes and fixes signs afterwards, which also
    // yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
    always_comb begin
        a_sx   = {{32{A[31]}}, A};
        b_sx   = {{32{B[31]}}, B};
        prod_s = a_sx * b_sx;
        prod_u = {32'b0, A} * {32'b0, B};
        a_mag  = A[31] ? (~A + 32'd1) : A;
        b_mag  = B[31] ? (~B + 32'd1) : B;
        dvd    = signed_div ? a_mag : A;
        dvs    = signed_div ? b_mag : B;
        // Divisor forced to 1 on divide-by-zero; the result is discarded anyway.
        if (dvs == 32'd0) dvs = 32'd1;
        q_raw  = dvd / dvs;
        r_raw  = dvd % dvs;
        res_hi_d = 32'd0;
        res_lo_d = 32'd0;
        commit_d = 1'b1;
        case (MD_op)
            OP_MULT:  begin res_hi_d = prod_s[63:32]; res_lo_d = prod_s[31:0]; end
            OP_MULTU: begin res_hi_d = prod_u[63:32]; res_lo_d = prod_u[31:0]; end
            OP_DIV: begin
                res_lo_d = (A[31] ^ B[31]) ? (~q_raw + 32'd1) : q_raw;
                res_hi_d = A[31] ? (~r_raw + 32'd1) : r_raw;
                commit_d = (B != 32'd0);
            end
            OP_DIVU: begin
                res_lo_d = q_raw;
                res_hi_d = r_raw;
                commit_d = (B != 32'd0);
            end
            default: ;
        endcase
    end

    // Control FSM: accept an op in IDLE, count down in RUN, commit HI/LO on the last busy edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            busy_q    <= 1'b0;
            commit_q  <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            temp_hi_q <= 32'd0;
            temp_lo_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!Req) begin
                        if (is_md_start) begin
                            temp_hi_q <= res_hi_d;
                            temp_lo_q <= res_lo_d;
                            commit_q  <= commit_d;
                            cnt_q     <= is_mult ? 8'(MULT_CYCLES) : 8'(DIV_CYCLES);
                            busy_q    <= 1'b1;
                            state_q   <= S_RUN;
                        end
                        if (MD_op == OP_MTHI) hi_q <= A;
                        if (MD_op == OP_MTLO) lo_q <= A;
                    end
                end
                S_RUN: begin
                    // Req does not abort: the running op belongs to an older, committed instruction.
                    if (cnt_q == 8'd1) begin
                        if (commit_q) begin
                            hi_q <= temp_hi_q;
                            lo_q <= temp_lo_q;
                        end
                        cnt_q   <= 8'd0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Move-from reads only the committed registers, never the in-flight result.
    always_comb begin
        md_out_d = 32'd0;
        if (MD_op == OP_MFHI) md_out_d = hi_q;
        else if (MD_op == OP_MFLO) md_out_d = lo_q;
    end

    assign busy   = busy_q;
    assign HI     = hi_q;
    assign LO     = lo_q;
    assign MD_out = md_out_d;

endmodule
